// File: rtl/blur_frame_sequencer_pkg.sv
// ============================================================================
// blur_frame_sequencer_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the frame sequencer in front of the gaussian blur
// stage of the hough_transform pipeline.
//
// Contents:
//   REDUCED_WIDTH / REDUCED_HEIGHT : reduced frame geometry. The blur stage
//                                    uses these same values, so the sequencer
//                                    defaults to them.
//   PIXEL_W                        : pixel width on both FIFO interfaces.
//   FRAME_COUNT_W                  : width of the completed-frame counter.
//   seq_state_t                    : sequencer FSM state encoding.
//   is_active()                    : true in the states where a frame is in
//                                    flight (FEED, DRAIN).
// ============================================================================
package blur_frame_sequencer_pkg;

    localparam int REDUCED_WIDTH  = 160;
    localparam int REDUCED_HEIGHT = 120;

    localparam int PIXEL_W       = 8;
    localparam int FRAME_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // A frame is "in flight" while input is being metered in or while the
    // sequencer is waiting for the blur stage to finish producing output.
    function automatic logic is_active(input seq_state_t s);
        return (s == FEED) || (s == DRAIN);
    endfunction

endpackage : blur_frame_sequencer_pkg

// File: rtl/blur_frame_sequencer_watchdog.sv
// ============================================================================
// seq_watchdog
// ----------------------------------------------------------------------------
// Idle-cycle watchdog for the DRAIN phase of the frame sequencer.
//
// The counter advances on every enabled cycle and is zeroed by clear. The
// expired flag is combinational and marks the enabled cycle that is the
// TIMEOUT-th consecutive idle cycle, so the owner can act on the same clock
// edge at which the count reaches TIMEOUT. The count saturates at TIMEOUT.
//
// Parameters:
//   TIMEOUT : number of consecutive enabled cycles before expiry (>= 1).
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high reset
//   clear   in   zero the count (takes priority over enable)
//   enable  in   count this cycle as an idle cycle
//   expired out  this enabled cycle is the TIMEOUT-th idle cycle
// ============================================================================
module seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != WD_W'(TIMEOUT))) begin
            count <= count + WD_W'(1);
        end
    end

    // The count already holds TIMEOUT-1 completed idle cycles, so this
    // enabled cycle is the TIMEOUT-th one.
    assign expired = enable && (count == WD_W'(TIMEOUT - 1));

endmodule : seq_watchdog

// File: rtl/blur_frame_sequencer.sv
// ============================================================================
// blur_frame_sequencer
// ----------------------------------------------------------------------------
// Frame-level controller in front of the gaussian blur stage. On start it
// meters exactly one frame of pixels from the upstream first-word-fall-through
// FIFO into the blur input FIFO, then watches the blur stage's writes into its
// output FIFO to detect frame completion. It reports busy, a one-cycle done
// pulse, a wrapping completed-frame counter and a sticky drain-timeout error,
// so the top level can re-arm the blur stage between frames without letting
// frames overlap.
//
// Parameters:
//   FRAME_W     : pixels per row fed to blur (default REDUCED_WIDTH)
//   FRAME_H     : rows per frame (default REDUCED_HEIGHT)
//   TIMEOUT     : max idle cycles in DRAIN between observed output writes
//   PIXEL_COUNT : FRAME_W*FRAME_H, pixels per frame in and out (derived)
//   CNT_W       : width of the per-frame pixel counters (derived)
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   start          in   request one frame; sampled only in IDLE
//   abort          in   terminate the current frame; return to IDLE
//   busy           out  high in FEED and DRAIN
//   done           out  one-cycle pulse when a frame completes cleanly
//   timeout_err    out  sticky drain timeout; cleared by accepted start/reset
//   frame_count    out  completed frames, wraps 0xFFFF -> 0
//   src_empty      in   upstream FIFO empty
//   src_rd_en      out  upstream FIFO pop
//   src_dout       in   upstream pixel (valid whenever !src_empty)
//   blur_in_full   in   blur input FIFO full
//   blur_in_wr_en  out  blur input FIFO push
//   blur_in_din    out  pixel to blur input FIFO
//   blur_out_wr_en in   observed blur write strobe into its output FIFO
//   blur_out_full  in   observed blur output FIFO full
//   pix_in_count   out  pixels forwarded this frame
//   pix_out_count  out  blur outputs observed this frame (saturating)
// ============================================================================
module blur_frame_sequencer
    import blur_frame_sequencer_pkg::*;
#(
    parameter  int FRAME_W     = REDUCED_WIDTH,
    parameter  int FRAME_H     = REDUCED_HEIGHT,
    parameter  int TIMEOUT     = 4096,
    localparam int PIXEL_COUNT = FRAME_W * FRAME_H,
    localparam int CNT_W       = $clog2(PIXEL_COUNT + 1)
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [FRAME_COUNT_W-1:0] frame_count,

    input  logic                     src_empty,
    output logic                     src_rd_en,
    input  logic [PIXEL_W-1:0]       src_dout,

    input  logic                     blur_in_full,
    output logic                     blur_in_wr_en,
    output logic [PIXEL_W-1:0]       blur_in_din,

    input  logic                     blur_out_wr_en,
    input  logic                     blur_out_full,

    output logic [CNT_W-1:0]         pix_in_count,
    output logic [CNT_W-1:0]         pix_out_count
);

    seq_state_t state;

    logic transfer;        // one pixel moves source -> blur this cycle
    logic out_evt;         // blur output write actually accepted
    logic out_counted;     // out_evt that belongs to the current frame
    logic start_accept;    // start honoured this cycle
    logic in_complete;     // all pixels of the frame forwarded
    logic out_complete;    // all blur outputs of the frame observed
    logic last_transfer;   // this transfer forwards the final pixel
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // ------------------------------------------------------------------------
    // Drain watchdog: counts idle DRAIN cycles, restarted by every accepted
    // blur output and by the start of a new frame.
    // ------------------------------------------------------------------------
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // ------------------------------------------------------------------------
    // Combinational handshake and event decode.
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        transfer      = 1'b0;
        out_evt       = 1'b0;
        out_counted   = 1'b0;
        start_accept  = 1'b0;
        in_complete   = 1'b0;
        out_complete  = 1'b0;
        last_transfer = 1'b0;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        src_rd_en     = 1'b0;
        blur_in_wr_en = 1'b0;
        blur_in_din   = '0;

        in_complete  = (pix_in_count  == CNT_W'(PIXEL_COUNT));
        out_complete = (pix_out_count == CNT_W'(PIXEL_COUNT));

        // The pop and push are the same strobe with zero added latency: the
        // source is first-word-fall-through, so src_dout is already the pixel
        // being popped. Reset and abort suppress the pop in their own cycle.
        transfer = !reset && !abort && (state == FEED) &&
                   !src_empty && !blur_in_full && !in_complete;

        last_transfer = transfer && (pix_in_count == CNT_W'(PIXEL_COUNT - 1));

        out_evt     = blur_out_wr_en && !blur_out_full;
        // Blur emits while input is still arriving, so outputs count in FEED
        // as well as DRAIN. Outputs in IDLE/DONE belong to no frame.
        out_counted = out_evt && is_active(state) && !abort;

        start_accept = (state == IDLE) && start && !abort;

        wd_clear  = start_accept || out_evt;
        wd_enable = (state == DRAIN) && !out_evt && !abort;

        src_rd_en     = transfer;
        blur_in_wr_en = transfer;
        blur_in_din   = transfer ? src_dout : '0;
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM with registered status outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            frame_count   <= '0;
            pix_in_count  <= '0;
            pix_out_count <= '0;
        end else begin
            done <= 1'b0;

            if (abort) begin
                // Abort beats every other transition. Counts are left as they
                // are so the frame's progress stays visible until next start.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                if (transfer) begin
                    pix_in_count <= pix_in_count + CNT_W'(1);
                end
                if (out_counted && !out_complete) begin
                    pix_out_count <= pix_out_count + CNT_W'(1);
                end

                unique case (state)
                    IDLE: begin
                        if (start_accept) begin
                            state         <= FEED;
                            busy          <= 1'b1;
                            timeout_err   <= 1'b0;
                            pix_in_count  <= '0;
                            pix_out_count <= '0;
                        end
                    end

                    FEED: begin
                        if (last_transfer) begin
                            state <= DRAIN;
                        end
                    end

                    DRAIN: begin
                        // Completion wins over a watchdog expiry in the same
                        // cycle: the frame is whole, so it is not an error.
                        if (out_complete) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            frame_count <= frame_count + FRAME_COUNT_W'(1);
                        end else if (wd_expired) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end
                    end

                    DONE: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : blur_frame_sequencer

// File: tb/tb_blur_frame_sequencer.sv
// ============================================================================
// tb_blur_frame_sequencer
// ----------------------------------------------------------------------------
// Directed bench for blur_frame_sequencer with an 8x4 frame and TIMEOUT=16.
// The source FIFO supplies pixel pix_val(n) as its n-th word. The blur model
// produces one output write four cycles after each push.
// Inputs are driven on the falling edge; outputs are observed 1 ns later.
// ============================================================================
module tb_blur_frame_sequencer;
    import blur_frame_sequencer_pkg::*;

    localparam int FW = 8;
    localparam int FH = 4;
    localparam int PC = FW * FH;
    localparam int TO = 16;
    localparam int CW = $clog2(PC + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, timeout_err;
    logic [15:0]   frame_count;
    logic          src_empty = 1'b1;
    logic          src_rd_en;
    logic [7:0]    src_dout = 8'h00;
    logic          blur_in_full = 1'b0;
    logic          blur_in_wr_en;
    logic [7:0]    blur_in_din;
    logic          blur_out_wr_en = 1'b0;
    logic          blur_out_full = 1'b0;
    logic [CW-1:0] pix_in_count, pix_out_count;

    blur_frame_sequencer #(
        .FRAME_W (FW),
        .FRAME_H (FH),
        .TIMEOUT (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err),
        .frame_count    (frame_count),
        .src_empty      (src_empty),
        .src_rd_en      (src_rd_en),
        .src_dout       (src_dout),
        .blur_in_full   (blur_in_full),
        .blur_in_wr_en  (blur_in_wr_en),
        .blur_in_din    (blur_in_din),
        .blur_out_wr_en (blur_out_wr_en),
        .blur_out_full  (blur_out_full),
        .pix_in_count   (pix_in_count),
        .pix_out_count  (pix_out_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    bit reset_v = 1'b0, start_v = 1'b0, abort_v = 1'b0;
    int empty_mode = 0;       // 0: never empty, 1: random
    int full_mode = 0;        // 0: never full, 1: toggles every cycle
    int out_full_mode = 0;    // 0: never full, 1: random 1-in-4
    int out_limit = 1 << 30;  // max outputs the blur model will emit

    // Model / bookkeeping state
    int         cyc = 0;
    int         src_idx = 0;
    int         owed = 0;
    int         out_emitted = 0;
    int         last_out_cyc = 0;
    int         done_pulses = 0;
    int         bad_push = 0;
    int         strobe_bad = 0;
    bit         last_rd = 1'b0;
    logic [2:0] dly = 3'b000;
    logic [7:0] push_q[$];

    function automatic logic [7:0] pix_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // One clock cycle: drive inputs, let combinational outputs settle, then
    // record what the DUT did in this cycle.
    task automatic cycle();
        @(negedge clock);
        reset = reset_v;
        start = start_v;
        abort = abort_v;
        src_empty      = (empty_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        blur_in_full   = (full_mode == 1) ? ~blur_in_full : 1'b0;
        src_dout       = pix_val(src_idx);
        blur_out_wr_en = (owed > 0) && (out_emitted < out_limit);
        blur_out_full  = (out_full_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
        #1;
        cyc++;
        last_rd = src_rd_en;
        if (src_rd_en !== blur_in_wr_en) strobe_bad++;
        if (blur_in_wr_en === 1'b1) begin
            push_q.push_back(blur_in_din);
            if (src_empty || blur_in_full) bad_push++;
        end else if (blur_in_din !== 8'h00) begin
            strobe_bad++;
        end
        if (src_rd_en === 1'b1) src_idx++;
        if (blur_out_wr_en && !blur_out_full) begin
            owed--;
            out_emitted++;
            last_out_cyc = cyc;
        end
        if (done === 1'b1) done_pulses++;
        if (dly[2]) owed++;
        dly = {dly[1:0], (blur_in_wr_en === 1'b1)};
    endtask

    task automatic clear_model();
        owed        = 0;
        dly         = 3'b000;
        out_emitted = 0;
        done_pulses = 0;
        bad_push    = 0;
        strobe_bad  = 0;
        push_q.delete();
    endtask

    // Runs cycles until done is seen; gap counts cycles where busy was low
    // before the done cycle.
    task automatic run_until_done(input int budget, output bit seen, output int gap);
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) gap++;
        end
    endtask

    function automatic int order_errors(input int base);
        int bad = 0;
        foreach (push_q[i]) if (push_q[i] !== pix_val(base + i)) bad++;
        return bad;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset_v = 1'b1;
        cycle();
        cycle();
        reset_v = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        checks++; if (src_rd_en !== 1'b0 || blur_in_wr_en !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0/0", src_rd_en, blur_in_wr_en); end
        checks++; if (pix_in_count !== '0 || pix_out_count !== '0) begin errors++; $display("FAIL reset_counts: got in=%0d out=%0d expected 0/0", pix_in_count, pix_out_count); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_frame();
        int  base, start_cyc, gap;
        bit  seen;
        clear_model();
        base    = src_idx;
        start_v = 1'b1;
        cycle();
        start_v   = 1'b0;
        start_cyc = cyc;
        cycle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame1_busy_after_start: got %b expected 1", busy); end
        run_until_done(200, seen, gap);
        checks++; if (!seen) begin errors++; $display("FAIL frame1_done_seen: got none expected a done pulse"); end
        checks++; if (cyc - start_cyc != 38) begin errors++; $display("FAIL frame1_done_latency: got %0d cycles expected 38", cyc - start_cyc); end
        checks++; if (gap != 0) begin errors++; $display("FAIL frame1_busy_gap: got %0d low cycles expected 0", gap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame1_busy_in_done: got %b expected 0", busy); end
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL frame1_done_pulses: got %0d expected 1", done_pulses); end
        checks++; if (push_q.size() != PC) begin errors++; $display("FAIL frame1_push_count: got %0d expected %0d", push_q.size(), PC); end
        checks++; if (order_errors(base) != 0) begin errors++; $display("FAIL frame1_data_order: got %0d wrong pixels expected 0", order_errors(base)); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL frame1_frame_count: got %0d expected 1", frame_count); end
        checks++; if (pix_out_count !== CW'(PC)) begin errors++; $display("FAIL frame1_pix_out_count: got %0d expected %0d", pix_out_count, PC); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        int base, gap, emitted_at_done;
        bit seen;
        clear_model();
        base          = src_idx;
        empty_mode    = 1;
        full_mode     = 1;
        out_full_mode = 1;
        start_v       = 1'b1;
        cycle();
        start_v = 1'b0;
        run_until_done(3000, seen, gap);
        emitted_at_done = out_emitted;
        empty_mode    = 0;
        full_mode     = 0;
        out_full_mode = 0;
        cycle();
        checks++; if (!seen) begin errors++; $display("FAIL bp_done_seen: got none expected a done pulse"); end
        checks++; if (bad_push != 0) begin errors++; $display("FAIL bp_push_while_blocked: got %0d expected 0", bad_push); end
        checks++; if (strobe_bad != 0) begin errors++; $display("FAIL bp_strobe_consistency: got %0d bad cycles expected 0", strobe_bad); end
        checks++; if (push_q.size() != PC) begin errors++; $display("FAIL bp_push_count: got %0d expected %0d", push_q.size(), PC); end
        checks++; if (order_errors(base) != 0) begin errors++; $display("FAIL bp_data_order: got %0d wrong pixels expected 0", order_errors(base)); end
        checks++; if (pix_in_count !== CW'(PC)) begin errors++; $display("FAIL bp_pix_in_count: got %0d expected %0d", pix_in_count, PC); end
        checks++; if (emitted_at_done != PC) begin errors++; $display("FAIL bp_outputs_before_done: got %0d expected %0d", emitted_at_done, PC); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL bp_frame_count: got %0d expected 2", frame_count); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
        int rise_cyc;
        bit seen;
        clear_model();
        out_limit = PC - 1;
        seen      = 1'b0;
        rise_cyc  = 0;
        start_v   = 1'b1;
        cycle();
        start_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (timeout_err === 1'b1) begin
                seen     = 1'b1;
                rise_cyc = cyc;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL to_err_seen: got 0 expected timeout_err=1"); end
        checks++; if (rise_cyc - last_out_cyc != TO + 1) begin errors++; $display("FAIL to_err_timing: got %0d cycles after last output expected %0d", rise_cyc - last_out_cyc, TO + 1); end
        checks++; if (busy !== 1'b0 || dut.state !== IDLE) begin errors++; $display("FAIL to_back_to_idle: got busy=%b state=%0d expected 0/IDLE", busy, dut.state); end
        checks++; if (pix_out_count !== CW'(PC - 1)) begin errors++; $display("FAIL to_pix_out_count: got %0d expected %0d", pix_out_count, PC - 1); end
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b expected 1", timeout_err); end
        checks++; if (done_pulses != 0) begin errors++; $display("FAIL to_no_done: got %0d pulses expected 0", done_pulses); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL to_frame_count: got %0d expected 2", frame_count); end
        out_limit = 1 << 30;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_abort();
        int base, gap;
        bit seen;
        clear_model();
        base    = src_idx;
        start_v = 1'b1;
        cycle();
        start_v = 1'b0;
        for (int i = 0; i < 50 && push_q.size() < 10; i++) cycle();
        abort_v = 1'b1;
        cycle();
        checks++; if (last_rd !== 1'b0 || blur_in_wr_en !== 1'b0) begin errors++; $display("FAIL abort_no_pop: got rd=%b wr=%b expected 0/0", last_rd, blur_in_wr_en); end
        abort_v = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0 || dut.state !== IDLE) begin errors++; $display("FAIL abort_idle: got busy=%b state=%0d expected 0/IDLE", busy, dut.state); end
        checks++; if (pix_in_count !== CW'(10) || src_idx - base != 10) begin errors++; $display("FAIL abort_pix_in_hold: got count=%0d pops=%0d expected 10/10", pix_in_count, src_idx - base); end
        checks++; if (pix_out_count !== CW'(6)) begin errors++; $display("FAIL abort_pix_out_hold: got %0d expected 6", pix_out_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL abort_err_cleared_by_start: got %b expected 0", timeout_err); end
        for (int i = 0; i < 6; i++) cycle();
        checks++; if (done_pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_pulses); end
        clear_model();
        base    = src_idx;
        start_v = 1'b1;
        cycle();
        start_v = 1'b0;
        cycle();
        checks++; if (pix_in_count !== '0 || pix_out_count !== '0) begin errors++; $display("FAIL abort_restart_clear: got in=%0d out=%0d expected 0/0", pix_in_count, pix_out_count); end
        run_until_done(200, seen, gap);
        checks++; if (!seen || push_q.size() != PC) begin errors++; $display("FAIL abort_restart_frame: got done=%b pushes=%0d expected 1/%0d", seen, push_q.size(), PC); end
        checks++; if (order_errors(base) != 0) begin errors++; $display("FAIL abort_restart_order: got %0d wrong pixels expected 0", order_errors(base)); end
        cycle();
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL abort_frame_count: got %0d expected 3", frame_count); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int base, d1, d2, first_push2, pushes_f1;
        clear_model();
        base        = src_idx;
        d1          = -1;
        d2          = -1;
        first_push2 = -1;
        pushes_f1   = 0;
        start_v     = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (d1 >= 0 && first_push2 < 0 && blur_in_wr_en === 1'b1) first_push2 = cyc;
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1        = cyc;
                    pushes_f1 = push_q.size();
                end else begin
                    d2 = cyc;
                    break;
                end
            end
        end
        start_v = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (done_pulses != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_pulses); end
        checks++; if (pushes_f1 != PC) begin errors++; $display("FAIL b2b_frame1_pushes: got %0d expected %0d", pushes_f1, PC); end
        checks++; if (push_q.size() != 2 * PC) begin errors++; $display("FAIL b2b_total_pushes: got %0d expected %0d", push_q.size(), 2 * PC); end
        checks++; if (order_errors(base) != 0) begin errors++; $display("FAIL b2b_data_order: got %0d wrong pixels expected 0", order_errors(base)); end
        checks++; if (first_push2 - d1 != 2) begin errors++; $display("FAIL b2b_restart_gap: got %0d cycles expected 2", first_push2 - d1); end
        checks++; if (d2 - d1 != 39) begin errors++; $display("FAIL b2b_done_spacing: got %0d cycles expected 39", d2 - d1); end
        checks++; if (frame_count !== 16'd5) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 5", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got busy=%b expected 0", busy); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_in_drain();
        bit in_drain;
        clear_model();
        in_drain = 1'b0;
        start_v  = 1'b1;
        cycle();
        start_v = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (dut.state === DRAIN) begin
                in_drain = 1'b1;
                break;
            end
        end
        checks++; if (!in_drain) begin errors++; $display("FAIL rst_reach_drain: got state=%0d expected DRAIN", dut.state); end
        reset_v = 1'b1;
        cycle();
        reset_v = 1'b0;
        cycle();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected IDLE", dut.state); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_flags: got busy=%b done=%b err=%b expected 0/0/0", busy, done, timeout_err); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
        checks++; if (src_rd_en !== 1'b0 || blur_in_wr_en !== 1'b0 || blur_in_din !== 8'h00) begin errors++; $display("FAIL rst_fifo_side: got rd=%b wr=%b din=%h expected 0/0/00", src_rd_en, blur_in_wr_en, blur_in_din); end
        checks++; if (pix_in_count !== '0 || pix_out_count !== '0) begin errors++; $display("FAIL rst_counts: got in=%0d out=%0d expected 0/0", pix_in_count, pix_out_count); end
        checks++; if (dut.u_watchdog.count !== '0) begin errors++; $display("FAIL rst_watchdog: got %0d expected 0", dut.u_watchdog.count); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_time_limit: got no completion expected summary before 500 us");
        $fatal(1, "time limit reached");
    end

endmodule : tb_blur_frame_sequencer

// File: doc/blur_frame_sequencer.md
Name: blur_frame_sequencer

Overview:
Frame-level controller in front of the gaussian blur stage of the hough_transform pipeline. On a start command it meters exactly one frame of 8-bit pixels from the upstream source FIFO into the blur stage's input FIFO. It monitors the blur stage's output-FIFO writes to detect frame completion. It reports busy, done, a frame counter and a drain-timeout error, so the top level can re-arm the blur stage between frames without overlapping frames.

Parameters:
FRAME_W, REDUCED_WIDTH (globals), pixels per row fed to blur
FRAME_H, REDUCED_HEIGHT (globals), rows per frame
PIXEL_COUNT, FRAME_W*FRAME_H, derived: pixels per frame in and out
TIMEOUT, 4096, max idle cycles in DRAIN between observed output writes before error
CNT_W, $clog2(PIXEL_COUNT+1), derived counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request one frame; sampled only in IDLE
abort  in  1  terminate current frame; return to IDLE
busy  out  1  high in FEED and DRAIN
done  out  1  one-cycle pulse when a frame completes cleanly
timeout_err  out  1  sticky; set on drain timeout, cleared by next accepted start or reset
frame_count  out  16  completed frames, wraps 0xFFFF->0
src_empty  in  1  upstream FIFO empty (first-word-fall-through)
src_rd_en  out  1  upstream FIFO pop
src_dout  in  8  upstream pixel
blur_in_full  in  1  blur input FIFO full
blur_in_wr_en  out  1  blur input FIFO push
blur_in_din  out  8  pixel to blur input FIFO
blur_out_wr_en  in  1  observed: blur stage write strobe to its output FIFO
blur_out_full  in  1  observed: blur output FIFO full
pix_in_count  out  CNT_W  pixels forwarded this frame
pix_out_count  out  CNT_W  blur outputs observed this frame

Behaviour:
- Reset values: state IDLE; busy=0, done=0, timeout_err=0, frame_count=0, src_rd_en=0, blur_in_wr_en=0, blur_in_din=0, both counts=0, watchdog=0.
- States:
  - IDLE: start=1 -> FEED next cycle. Clears both counts, the watchdog and timeout_err.
  - FEED: transfer = !src_empty && !blur_in_full && pix_in_count<PIXEL_COUNT.
    - src_rd_en = blur_in_wr_en = transfer, combinational.
    - blur_in_din = src_dout when transfer, else 0.
    - Zero added latency; at most one pixel per cycle.
    - pix_in_count increments on transfer.
    - After the transfer that makes pix_in_count==PIXEL_COUNT -> DRAIN.
  - DRAIN: no src pops. Exit conditions:
    - pix_out_count==PIXEL_COUNT -> DONE.
    - watchdog reaches TIMEOUT -> IDLE with timeout_err=1; done not pulsed and frame_count unchanged.
  - DONE: done=1 for exactly this cycle; frame_count+1; -> IDLE. busy=0 in DONE.
- Output observation: out_evt = blur_out_wr_en && !blur_out_full.
  - Counted in FEED and DRAIN, because blur emits while frame input is still arriving.
  - pix_out_count saturates at PIXEL_COUNT.
  - Events in IDLE/DONE are ignored.
- Watchdog: counts only in DRAIN; reset to 0 on each out_evt.
- Boundaries:
  - Back-to-back: start high in the cycle after DONE is accepted (IDLE) with no bubble beyond the IDLE cycle.
  - start outside IDLE is ignored, with no queuing.
  - abort has priority over every other transition: -> IDLE next cycle. No pop occurs in the abort cycle; counts hold until the next start clears them; done not pulsed.
  - src_empty and blur_in_full simultaneous: no transfer; both strobes 0.
  - Synchronous reset mid-frame returns all state to reset values on the next edge. Flushing blur's internal state is the top level's responsibility; it pulses blur reset alongside.
  - frame_count wraps silently.

Decomposition:
- Shared package (globals): seq_state_t enum {IDLE, FEED, DRAIN, DONE}; REDUCED_WIDTH and REDUCED_HEIGHT come from there as already used by the blur stage.
- One natural sub-module: seq_watchdog (load/clear, enable, terminal-count flag, parameter TIMEOUT).
- Everything else stays in one always_ff plus one always_comb.

Test Plan:
1. FRAME_W=8, FRAME_H=4 (32 px), source always non-empty, blur_in never full, blur model emits 32 writes. Required response:
   - exactly 32 pushes with data matching the source order;
   - busy high from the cycle after start until DRAIN exits;
   - done pulse exactly once; frame_count=1; pix_out_count=32.
2. Backpressure: toggle blur_in_full every cycle and make src_empty random. Required response: no push while full or empty, no lost or duplicated pixel, pix_in_count ends at 32.
3. Timeout with TIMEOUT=16: the blur model emits only 31 outputs. Required response: timeout_err=1 exactly 16 cycles after the last out_evt in DRAIN, done never asserted, frame_count unchanged, return to IDLE.
4. abort asserted after 10 transfers, while src_empty=0. Required response: no pop in the abort cycle, IDLE next cycle, pix_in_count holds 10; the next start clears the counts and a full 32-pixel frame then completes.
5. Two back-to-back frames with start held high continuously. Required response: two done pulses, frame_count=2, 64 total pushes; start during FEED/DRAIN has no effect.
6. Synchronous reset asserted in DRAIN. Required response: every output at its reset value after the next edge, with state IDLE.
